// File: rtl/fwd_hazard_unit.sv
// EX-stage operand forwarding and load-use hazard controller.
// Shadows the ID/EX and EX/MEM destinations to build registered mux selects.
module fwd_hazard_unit #(
  parameter int REG_W = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rsrc,
  input  logic [REG_W-1:0] id_rdst,
  input  logic             id_use_rsrc,
  input  logic             id_use_rdst,
  input  logic             id_wb_en,
  input  logic             id_is_load,
  input  logic             flush,
  input  logic             mem_busy,
  output logic [1:0]       ex_sel_src,
  output logic [1:0]       ex_sel_dst,
  output logic             stall,
  output logic             bubble,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [1:0] SEL_EX  = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_RF  = 2'b10;

  typedef enum logic {RUN, LU} state_e;

  state_e             state_q, state_d;
  logic               ex_v_q, ex_wb_q, ex_ld_q;
  logic               ex_v_d, ex_wb_d, ex_ld_d;
  logic [REG_W-1:0]   ex_dst_q, ex_dst_d;
  logic               mem_v_q, mem_wb_q, mem_ld_q;
  logic               mem_v_d, mem_wb_d, mem_ld_d;
  logic [REG_W-1:0]   mem_dst_q, mem_dst_d;
  logic [1:0]         sel_src_q, sel_src_d;
  logic [1:0]         sel_dst_q, sel_dst_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic       hit_ex_src, hit_ex_dst, hit_mem_src, hit_mem_dst;
  logic       lu, kill;
  logic [1:0] sel_src_c, sel_dst_c;

  assign hit_ex_src  = ex_v_q  & ex_wb_q  & (ex_dst_q  == id_rsrc);
  assign hit_ex_dst  = ex_v_q  & ex_wb_q  & (ex_dst_q  == id_rdst);
  assign hit_mem_src = mem_v_q & mem_wb_q & (mem_dst_q == id_rsrc);
  assign hit_mem_dst = mem_v_q & mem_wb_q & (mem_dst_q == id_rdst);

  // Most recent producer wins: EX before MEM before register file.
  assign sel_src_c = !id_use_rsrc ? SEL_RF  :
                     hit_ex_src   ? SEL_EX  :
                     hit_mem_src  ? SEL_MEM : SEL_RF;
  assign sel_dst_c = !id_use_rdst ? SEL_RF  :
                     hit_ex_dst   ? SEL_EX  :
                     hit_mem_dst  ? SEL_MEM : SEL_RF;

  assign lu = id_valid & ex_ld_q & ex_v_q & ex_wb_q &
              ((id_use_rsrc & hit_ex_src) | (id_use_rdst & hit_ex_dst));

  always_comb begin
    state_d   = state_q;
    ex_v_d    = ex_v_q;
    ex_wb_d   = ex_wb_q;
    ex_ld_d   = ex_ld_q;
    ex_dst_d  = ex_dst_q;
    mem_v_d   = mem_v_q;
    mem_wb_d  = mem_wb_q;
    mem_ld_d  = mem_ld_q;
    mem_dst_d = mem_dst_q;
    sel_src_d = sel_src_q;
    sel_dst_d = sel_dst_q;
    cnt_d     = cnt_q;
    stall     = 1'b0;
    bubble    = 1'b0;
    kill      = 1'b0;

    if (!rst_n) begin
      stall  = 1'b0;
      bubble = 1'b0;
    end else if (mem_busy) begin
      stall = 1'b1;
    end else begin
      state_d = RUN;
      // LU never re-stalls: ex_rec holds the bubble so lu cannot fire there anyway.
      if (state_q == RUN && lu && !flush) begin
        stall   = 1'b1;
        bubble  = 1'b1;
        state_d = LU;
        cnt_d   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
      end
      mem_v_d   = ex_v_q;
      mem_wb_d  = ex_wb_q;
      mem_ld_d  = ex_ld_q;
      mem_dst_d = ex_dst_q;
      kill      = bubble | flush | !id_valid;
      ex_v_d    = !kill;
      ex_wb_d   = !kill & id_wb_en;
      ex_ld_d   = !kill & id_is_load;
      ex_dst_d  = kill ? '0 : id_rdst;
      sel_src_d = (bubble | flush) ? SEL_RF : sel_src_c;
      sel_dst_d = (bubble | flush) ? SEL_RF : sel_dst_c;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= RUN;
      ex_v_q    <= 1'b0;
      ex_wb_q   <= 1'b0;
      ex_ld_q   <= 1'b0;
      ex_dst_q  <= '0;
      mem_v_q   <= 1'b0;
      mem_wb_q  <= 1'b0;
      mem_ld_q  <= 1'b0;
      mem_dst_q <= '0;
      sel_src_q <= SEL_RF;
      sel_dst_q <= SEL_RF;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      ex_v_q    <= ex_v_d;
      ex_wb_q   <= ex_wb_d;
      ex_ld_q   <= ex_ld_d;
      ex_dst_q  <= ex_dst_d;
      mem_v_q   <= mem_v_d;
      mem_wb_q  <= mem_wb_d;
      mem_ld_q  <= mem_ld_d;
      mem_dst_q <= mem_dst_d;
      sel_src_q <= sel_src_d;
      sel_dst_q <= sel_dst_d;
      cnt_q     <= cnt_d;
    end
  end

  assign ex_sel_src  = sel_src_q;
  assign ex_sel_dst  = sel_dst_q;
  assign stall_count = cnt_q;

endmodule
